// File: rtl/kab_bkd_pkg.sv
// kab_bkd_pkg: shared types, default constants and counter sizing for the BKD key debouncer.
`default_nettype none

package kab_bkd_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int unsigned DEF_NUM_KEYS        = 4;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;

  // Bits needed to count 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: one key - synchroniser, debounce FSM, registered level/pulses.
// Optional auto-repeat of the press pulse when KEY_REPEAT_EN is defined.
`default_nettype none

module key_debounce_channel
  import kab_bkd_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic Clock,
  input  logic Reset,
  input  logic key_raw_i,
  output logic key_state_o,
  output logic key_press_o,
  output logic key_release_o
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  key_state_e             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  logic                   rep_fire;

  // Raw pin is active-low; the synchroniser resets to the released level.
  assign s = ~sync_q[SYNC_STAGES-1];

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync_q    <= '1;
      state_q   <= RELEASED;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], key_raw_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = rep_fire;
    release_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW = cnt_width(REP_MAX);
  localparam logic [RW-1:0] REP_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_q, rep_d;
  logic          armed_q, armed_d;

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      rep_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      rep_q   <= rep_d;
      armed_q <= armed_d;
    end
  end

  // Counts only while staying in PRESSED; held through RELEASE_WAIT, cleared elsewhere.
  always_comb begin
    rep_d    = rep_q;
    armed_d  = armed_q;
    rep_fire = 1'b0;
    if (state_q == PRESSED && s) begin
      if (rep_q == (armed_q ? REP_PERIOD_LAST : REP_DELAY_LAST)) begin
        rep_fire = 1'b1;
        rep_d    = '0;
        armed_d  = 1'b1;
      end else begin
        rep_d = rep_q + RW'(1);
      end
    end else if (state_q == RELEASED || state_q == PRESS_WAIT) begin
      rep_d   = '0;
      armed_d = 1'b0;
    end
  end
`else
  logic unused_repeat;
  assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_fire      = 1'b0;
`endif

  assign key_state_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;

endmodule

`default_nettype wire

// File: rtl/key_debouncer.sv
// key_debouncer: NUM_KEYS independent debounced key channels for the BKD key inputs.
// Define KEY_REPEAT_EN to enable auto-repeat press pulses.
`default_nettype none

module key_debouncer
  import kab_bkd_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = DEF_NUM_KEYS,
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [NUM_KEYS-1:0] KeysRaw,
  output logic [NUM_KEYS-1:0] KeyState,
  output logic [NUM_KEYS-1:0] KeyPress,
  output logic [NUM_KEYS-1:0] KeyRelease
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .Clock        (Clock),
      .Reset        (Reset),
      .key_raw_i    (KeysRaw[i]),
      .key_state_o  (KeyState[i]),
      .key_press_o  (KeyPress[i]),
      .key_release_o(KeyRelease[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: table vectors, corner-case sequences and random stimulus against a run-length reference model.
`default_nettype none

module tb_key_debouncer;

  localparam int NK = 4;
  localparam int SS = 2;
  localparam int DC = 8;
  localparam int RD = 20;
  localparam int RP = 5;
`ifdef KEY_REPEAT_EN
  localparam bit REP_ON = 1'b1;
`else
  localparam bit REP_ON = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Reset;
  logic [NK-1:0] KeysRaw;
  logic [NK-1:0] KeyState, KeyPress, KeyRelease;

  always #5 Clock = ~Clock;

  key_debouncer #(
    .NUM_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clock(Clock), .Reset(Reset), .KeysRaw(KeysRaw),
    .KeyState(KeyState), .KeyPress(KeyPress), .KeyRelease(KeyRelease)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: raw delayed two samples, a key flips once the opposite level has run DC edges.
  logic [NK-1:0] h0, h1, m_state, m_press, m_rel;
  int            m_run [NK];
  int            m_held[NK];

  task automatic check(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    if (!Reset) begin
      h0 = '1; h1 = '1; m_state = '0; m_press = '0; m_rel = '0;
      for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_held[k] = 0; end
    end else begin
      for (int k = 0; k < NK; k++) begin
        logic s, stay, p, r;
        s = ~h1[k];
        p = 1'b0; r = 1'b0;
        stay = m_state[k] && (m_run[k] == 0) && s;
        if (s != m_state[k]) begin
          m_run[k]++;
          if (m_run[k] == DC) begin
            m_state[k] = s; m_run[k] = 0; m_held[k] = 0;
            if (s) p = 1'b1; else r = 1'b1;
          end
        end else begin
          m_run[k] = 0;
        end
        if (stay) begin
          m_held[k]++;
          if (REP_ON && (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RP == 0)))
            p = 1'b1;
        end
        m_press[k] = p; m_rel[k] = r;
      end
      h1 = h0; h0 = KeysRaw;
    end
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    check("model_KeyState", KeyState, m_state);
    check("model_KeyPress", KeyPress, m_press);
    check("model_KeyRelease", KeyRelease, m_rel);
  endtask

  typedef struct {
    logic          rst;
    logic [NK-1:0] raw;
    int            hold;
    logic [NK-1:0] st, pr, rl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt, lat;
    Reset   = 1'b0;
    KeysRaw = '0;

    tbl.push_back('{1'b0, 4'b0000, 3, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'b0000, 9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'b0000, 1, 4'hF, 4'hF, 4'h0});
    tbl.push_back('{1'b1, 4'b0000, 1, 4'hF, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'b1111, 9, 4'hF, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'b1111, 1, 4'h0, 4'h0, 4'hF});
    tbl.push_back('{1'b1, 4'b1111, 1, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'b1110, 9, 4'h0, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'b1110, 1, 4'h1, 4'h1, 4'h0});
    tbl.push_back('{1'b1, 4'b1110, 1, 4'h1, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'b1111, 9, 4'h1, 4'h0, 4'h0});
    tbl.push_back('{1'b1, 4'b1111, 1, 4'h0, 4'h0, 4'h1});
    tbl.push_back('{1'b1, 4'b1111, 1, 4'h0, 4'h0, 4'h0});

    foreach (tbl[i]) begin
      Reset   = tbl[i].rst;
      KeysRaw = tbl[i].raw;
      repeat (tbl[i].hold) step();
      check("tbl_KeyState", KeyState, tbl[i].st);
      check("tbl_KeyPress", KeyPress, tbl[i].pr);
      check("tbl_KeyRelease", KeyRelease, tbl[i].rl);
    end

    // Bounce on key 1: low 5, high 1, four times, then settle low.
    cnt = 0;
    for (int r = 0; r < 4; r++) begin
      KeysRaw[1] = 1'b0;
      repeat (5) begin step(); if (KeyPress[1]) cnt++; end
      KeysRaw[1] = 1'b1;
      step(); if (KeyPress[1]) cnt++;
    end
    check_int("bounce_no_pulse", cnt, 0);
    KeysRaw[1] = 1'b0;
    lat = 0;
    while (lat < 30 && !KeyPress[1]) begin step(); lat++; end
    check_int("bounce_settle_latency", lat, SS + DC);
    KeysRaw[1] = 1'b1;
    repeat (12) step();

    // Release glitch on key 2 while pressed.
    KeysRaw[2] = 1'b0;
    repeat (12) step();
    check("glitch_pressed", KeyState & 4'b0100, 4'b0100);
    KeysRaw[2] = 1'b1;
    repeat (3) step();
    KeysRaw[2] = 1'b0;
    cnt = 0;
    repeat (15) begin step(); if (KeyRelease[2] || !KeyState[2]) cnt++; end
    check_int("glitch_no_release", cnt, 0);
    KeysRaw[2] = 1'b1;
    repeat (12) step();

    // Reset four cycles into PRESS_WAIT on key 0.
    KeysRaw[0] = 1'b0;
    repeat (SS + 4) step();
    Reset = 1'b0;
    repeat (3) step();
    check("rst_mid_KeyState", KeyState, 4'h0);
    check("rst_mid_KeyPress", KeyPress, 4'h0);
    KeysRaw = '1;
    Reset   = 1'b1;
    cnt = 0;
    repeat (15) begin step(); if (KeyPress[0]) cnt++; end
    check_int("rst_mid_no_press", cnt, 0);

    // Key 3 held 50 cycles past the accepted press.
    KeysRaw[3] = 1'b0;
    lat = 0;
    while (lat < 30 && !KeyPress[3]) begin step(); lat++; end
    check_int("hold_press_latency", lat, SS + DC);
    cnt = 0;
    repeat (50) begin step(); if (KeyPress[3]) cnt++; end
    check_int("hold_repeat_pulses", cnt, REP_ON ? 7 : 0);
    KeysRaw[3] = 1'b1;
    repeat (12) step();

    // Random: short runs first (mostly rejected), then long runs with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(c < 1500 ? 9 : 39, 0) == 0) KeysRaw[k] = ~KeysRaw[k];
      Reset = ($urandom_range(399, 0) == 0) ? 1'b0 : 1'b1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
